fifo_rptr_empty: RTL and testbench



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_sync_w2r.sv | 33 +++
 rtl/fifo_rptr_empty.sv | 77 +++++++
 tb/tb_fifo_rptr_empty.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared Gray/binary helpers for the async FIFO read and write pointer blocks.
`default_nettype none

package fifo_pkg;

  localparam int ADDRSIZE_DEFAULT = 8;

  // Width-generic by operating on 32 bits; callers size-cast the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync_w2r.sv
// Multi-flop synchroniser carrying the Gray write pointer into the read clock domain.
`default_nettype none

module fifo_sync_w2r #(
  parameter int W           = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic         rclk,
  input  logic         rrst,
  input  logic [W-1:0] wptr_i,
  output logic [W-1:0] rq_wptr_o
);

  logic [W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq_wptr_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fifo_rptr_empty.sv
// Async FIFO read-side control: read pointer, wptr synchroniser, empty/almost-empty/level flags.
`default_nettype none

module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = ADDRSIZE_DEFAULT,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] C_THRESH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] rq_wptr;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic [PW-1:0] wbin;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;

  fifo_sync_w2r #(
    .W           (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .rclk      (rclk),
    .rrst      (rrst),
    .wptr_i    (wptr),
    .rq_wptr_o (rq_wptr)
  );

  always_comb begin
    rbin_d    = rbin_q + PW'(rinc & ~rempty_q);
    rptr_d    = PW'(bin2gray(32'(rbin_d)));
    wbin      = PW'(gray2bin(32'(rq_wptr)));
    // Level uses the stale synchronised wptr, so it can only understate.
    rlevel_d  = wbin - rbin_d;
    rempty_d  = (rptr_d == rq_wptr);
    raempty_d = (rlevel_d <= C_THRESH);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
    end
  end

  assign raddr         = rbin_q[ADDRSIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = raempty_q;
  assign rlevel        = rlevel_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rptr_empty.sv
// Directed self-checking bench for fifo_rptr_empty (ADDRSIZE=8, SYNC_STAGES=2, AEMPTY_THRESH=4).
`default_nettype none

module tb_fifo_rptr_empty;

  logic       rclk;
  logic       rrst;
  logic       rinc;
  logic [8:0] wptr;
  logic [7:0] raddr;
  logic [8:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [8:0] rlevel;

  int n_tests;
  int n_fail;

  fifo_rptr_empty #(
    .ADDRSIZE      (8),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (4)
  ) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rinc          (rinc),
    .wptr          (wptr),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic do_reset(input logic [8:0] w);
    rrst = 1'b1;
    rinc = 1'b0;
    wptr = w;
    step(2);
    rrst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rrst = 1'b0;
    rinc = 1'b0;
    wptr = 9'h000;
    #2 rrst = 1'b1;
    #1;
    check("rst_rempty", rempty, 1);
    check("rst_raempty", ralmost_empty, 1);
    check("rst_rlevel", rlevel, 0);
    check("rst_raddr", raddr, 0);
    check("rst_rptr", rptr, 0);
    step(2);
    rrst = 1'b0;

    // Empty deassert latency: one write visible after 3 edges
    wptr = 9'h001;
    step(2);
    check("lat_edge2_rempty", rempty, 1);
    step(1);
    check("lat_edge3_rempty", rempty, 0);
    check("lat_rlevel", rlevel, 1);
    check("lat_raempty", ralmost_empty, 1);

    // Read while empty is ignored
    do_reset(9'h000);
    rinc = 1'b1;
    step(10);
    check("rde_raddr", raddr, 0);
    check("rde_rptr", rptr, 0);
    check("rde_rempty", rempty, 1);
    rinc = 1'b0;

    // Mid-run async reset with rbin=37 (wptr = gray(40) = 0x3C)
    do_reset(9'h03C);
    step(3);
    rinc = 1'b1;
    step(37);
    rinc = 1'b0;
    check("mid_raddr37", raddr, 37);
    check("mid_rempty_pre", rempty, 0);
    check("mid_rlevel_pre", rlevel, 3);
    #2 rrst = 1'b1;
    #1;
    check("mid_rempty", rempty, 1);
    check("mid_raempty", ralmost_empty, 1);
    check("mid_rlevel", rlevel, 0);
    check("mid_raddr", raddr, 0);
    check("mid_rptr", rptr, 0);
    wptr = 9'h000;
    step(2);
    rrst = 1'b0;

    // Almost-empty threshold: wptr = gray(6) = 0x005
    do_reset(9'h005);
    step(4);
    check("ae_lvl6", rlevel, 6);
    check("ae_flag6", ralmost_empty, 0);
    check("ae_addr0", raddr, 0);
    rinc = 1'b1;
    step(1);
    check("ae_lvl5", rlevel, 5);
    check("ae_flag5", ralmost_empty, 0);
    check("ae_addr1", raddr, 1);
    step(1);
    check("ae_lvl4", rlevel, 4);
    check("ae_flag4", ralmost_empty, 1);
    check("ae_addr2", raddr, 2);
    rinc = 1'b0;

    // Wrap: wptr = gray(258) = 0x183, advance rbin to 255 then 3 reads
    do_reset(9'h183);
    step(3);
    rinc = 1'b1;
    step(255);
    check("wr_raddr255", raddr, 255);
    step(1);
    check("wr_raddr0", raddr, 0);
    step(1);
    check("wr_raddr1", raddr, 1);
    step(1);
    check("wr_raddr2", raddr, 2);
    check("wr_rptr", rptr, 9'h183);
    check("wr_rempty", rempty, 1);
    check("wr_rlevel", rlevel, 0);
    rinc = 1'b0;

    // Full depth: wptr = gray(256) = 0x180
    do_reset(9'h180);
    step(3);
    check("fd_rlevel256", rlevel, 256);
    check("fd_rempty0", rempty, 0);
    rinc = 1'b1;
    step(255);
    check("fd_rempty_255", rempty, 0);
    check("fd_rlevel1", rlevel, 1);
    step(1);
    check("fd_rempty_256", rempty, 1);
    check("fd_raddr", raddr, 0);
    check("fd_rptr", rptr, 9'h180);
    step(2);
    check("fd_noextra_raddr", raddr, 0);
    check("fd_noextra_rptr", rptr, 9'h180);
    check("fd_noextra_rlevel", rlevel, 0);
    rinc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
